weight_monitor: RTL and testbench
=================================

Name: weight_monitor

Overview:
Clocked, parametrised successor to the elevator cab's weight-limit logic. It tracks cab occupancy from asynchronous enter and exit sensor pulses, which count only while the door is open. It drives an overload flag with hysteresis, a near-limit warning and a door-hold request to the door controller. An optional timed alarm escalates persistent overload.

Parameters:
CW, 4, occupancy counter width in bits; MAX_COUNT = 2**CW-1 (derived)
CAPACITY, 5, largest legal occupancy; CAPACITY+1 enters overload; must be < MAX_COUNT
WARN_LEVEL, 4, near_limit asserts at occupancy >= WARN_LEVEL; must be <= CAPACITY
HYST, 1, overload releases at occupancy <= CAPACITY-HYST; 0 <= HYST <= CAPACITY
ALARM_CYCLES, 1000, overload persistence (clk cycles) before alarm; used only with the optional feature

Ports:
clk  in  1  system clock, rising edge
weight_flip_reset  in  1  reset, asynchronous, active-high
door  in  1  door open, synchronous to clk; counting enabled while 1
enter_flip  in  1  raw asynchronous sensor, rising edge = one person enters
exit_flip  in  1  raw asynchronous sensor, rising edge = one person exits
occupancy  out  CW  current registered count
near_limit  out  1  occupancy >= WARN_LEVEL
weight_limit_exceeded  out  1  state == OVERLOAD
door_hold  out  1  request to keep door open; equals weight_limit_exceeded
alarm  out  1  persistent-overload alarm (optional feature)

Behaviour:
- Reset (async assert, sync release): occupancy=0, state NORMAL, all outputs 0, synchroniser and edge history flops 0, arm counter 0.
- Each of enter_flip and exit_flip passes through a 2-flop synchroniser and then a history flop. event = sync & ~hist, one cycle wide.
- Arming: events are suppressed for the first 3 clk cycles after reset release, so a sensor already high at release is not counted.
- Latency: an input rising edge (stable >= 2 cycles) updates occupancy at the 3rd clk edge after capture; flags follow 1 cycle later (registered from the new occupancy).
- Count update, applied only when door=1 in the event cycle:
  enter only: +1, saturating at MAX_COUNT.
  exit only: -1, floor at 0 (no wrap).
  enter and exit in the same cycle: no change.
- door=0: events are discarded, not queued.
- FSM, 2 states:
  NORMAL -> OVERLOAD when occupancy > CAPACITY.
  OVERLOAD -> NORMAL when occupancy <= CAPACITY-HYST.
  Between those thresholds the state holds.
- near_limit is registered, with no hysteresis.
- Door closing while in OVERLOAD does not clear state; door_hold stays asserted. Occupancy can only fall via exit events with door=1.
- Reset mid-operation: immediate return to reset values; in-flight synchroniser events are lost.

Optional Feature:
Macro WEIGHT_ALARM_TIMEOUT_EN.
- Defined: a cycle counter clears on OVERLOAD entry and increments each cycle in OVERLOAD, saturating at ALARM_CYCLES. alarm is registered and asserts the cycle after the counter reaches ALARM_CYCLES. alarm and the counter clear on the cycle the FSM returns to NORMAL, and on reset.
- Undefined: alarm is tied to 0 and no counter logic exists.

Decomposition:
- Package weight_pkg: the FSM state enum (NORMAL, OVERLOAD), the SYNC_STAGES=2 and ARM_CYCLES=3 constants, and the default CAPACITY/WARN_LEVEL/HYST values.
- Sub-module pulse_sync_edge: 2-flop synchroniser plus history flop and arm gating, producing a one-cycle event. Instantiated twice (enter_flip, exit_flip).

Test Plan:
- Door=1, 6 enter edges (defaults) -> occupancy 1..6; near_limit rises at 4; weight_limit_exceeded and door_hold rise 1 cycle after occupancy=6.
- From 6 (OVERLOAD), one exit -> occupancy 5, overload stays 1. Second exit -> occupancy 4, overload drops 1 cycle later. Re-enter to 5 -> overload stays 0.
- Door=0, 3 enter edges -> occupancy unchanged. Enter and exit edges synchronised into the same cycle with door=1 -> no change. Exit at occupancy 0 -> stays 0. CW=3, CAPACITY=5, 10 enters -> saturates at 7.
- enter_flip held high across reset release -> no count. Reset asserted mid-count at occupancy 3 -> all outputs 0 asynchronously; next enter edge gives occupancy 1.
- With WEIGHT_ALARM_TIMEOUT_EN, ALARM_CYCLES=8: hold OVERLOAD -> alarm=1 at cycle 9 after entry. One exit to occupancy 5 -> alarm stays 1. Exit to 4 -> alarm clears with the state. Without the macro, alarm stays 0 throughout.

Source files
------------

// File: rtl/weight_monitor_pkg.sv
// Shared types and constants for the elevator cab weight monitor.
package weight_pkg;

  typedef enum logic {
    NORMAL   = 1'b0,
    OVERLOAD = 1'b1
  } wstate_t;

  localparam int SYNC_STAGES = 2;
  localparam int ARM_CYCLES  = 3;

  localparam int DEF_CAPACITY   = 5;
  localparam int DEF_WARN_LEVEL = 4;
  localparam int DEF_HYST       = 1;

endpackage

// File: rtl/weight_monitor_pulse_sync_edge.sv
// Synchronises one raw asynchronous sensor and emits a single-cycle pulse per
// rising edge, muted until the arm window after reset has elapsed.
module pulse_sync_edge
  import weight_pkg::*;
(
  input  logic clk,
  input  logic weight_flip_reset,
  input  logic raw,
  output logic pulse
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_CYCLES);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   hist;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   armed;

  // History keeps tracking while unarmed so a level already high at release
  // is absorbed instead of looking like a fresh edge once armed.
  always_ff @(posedge clk or posedge weight_flip_reset) begin
    if (weight_flip_reset) begin
      sync_chain <= '0;
      hist       <= 1'b0;
      arm_cnt    <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
      hist       <= sync_chain[SYNC_STAGES-1];
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign armed = (arm_cnt == ARM_DONE);
  assign pulse = armed & sync_chain[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/weight_monitor.sv
// Cab occupancy tracker with hysteretic overload flag, near-limit warning and
// door-hold request. Optional persistent-overload alarm: WEIGHT_ALARM_TIMEOUT_EN.
module weight_monitor
  import weight_pkg::*;
#(
  parameter int CW           = 4,
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int WARN_LEVEL   = DEF_WARN_LEVEL,
  parameter int HYST         = DEF_HYST,
  parameter int ALARM_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          weight_flip_reset,
  input  logic          door,
  input  logic          enter_flip,
  input  logic          exit_flip,
  output logic [CW-1:0] occupancy,
  output logic          near_limit,
  output logic          weight_limit_exceeded,
  output logic          door_hold,
  output logic          alarm
);

  localparam logic [CW-1:0] MAX_COUNT = {CW{1'b1}};
  localparam logic [CW-1:0] CAP_C     = CW'(CAPACITY);
  localparam logic [CW-1:0] RELEASE_C = CW'(CAPACITY - HYST);
  localparam logic [CW-1:0] WARN_C    = CW'(WARN_LEVEL);

  logic    enter_pulse;
  logic    exit_pulse;
  wstate_t state;

  pulse_sync_edge u_enter_sync (
    .clk               (clk),
    .weight_flip_reset (weight_flip_reset),
    .raw               (enter_flip),
    .pulse             (enter_pulse)
  );

  pulse_sync_edge u_exit_sync (
    .clk               (clk),
    .weight_flip_reset (weight_flip_reset),
    .raw               (exit_flip),
    .pulse             (exit_pulse)
  );

  // Simultaneous enter and exit cancel; closed-door events are dropped.
  always_ff @(posedge clk or posedge weight_flip_reset) begin
    if (weight_flip_reset) begin
      occupancy <= '0;
    end else if (door && (enter_pulse ^ exit_pulse)) begin
      if (enter_pulse) begin
        if (occupancy != MAX_COUNT) occupancy <= occupancy + 1'b1;
      end else begin
        if (occupancy != '0) occupancy <= occupancy - 1'b1;
      end
    end
  end

  // Flags are registered from the already-registered count, one cycle behind it.
  always_ff @(posedge clk or posedge weight_flip_reset) begin
    if (weight_flip_reset) begin
      state                 <= NORMAL;
      near_limit            <= 1'b0;
      weight_limit_exceeded <= 1'b0;
      door_hold             <= 1'b0;
    end else begin
      near_limit <= (occupancy >= WARN_C);
      case (state)
        NORMAL: begin
          if (occupancy > CAP_C) begin
            state                 <= OVERLOAD;
            weight_limit_exceeded <= 1'b1;
            door_hold             <= 1'b1;
          end
        end
        OVERLOAD: begin
          if (occupancy <= RELEASE_C) begin
            state                 <= NORMAL;
            weight_limit_exceeded <= 1'b0;
            door_hold             <= 1'b0;
          end
        end
        default: begin
          state                 <= NORMAL;
          weight_limit_exceeded <= 1'b0;
          door_hold             <= 1'b0;
        end
      endcase
    end
  end

`ifdef WEIGHT_ALARM_TIMEOUT_EN
  localparam int AW = $clog2(ALARM_CYCLES + 1);
  localparam logic [AW-1:0] ALARM_C = AW'(ALARM_CYCLES);

  logic [AW-1:0] alarm_cnt;
  logic          leaving;

  assign leaving = (state == OVERLOAD) && (occupancy <= RELEASE_C);

  // Counter is zero on the entry edge, so alarm lands ALARM_CYCLES+1 edges later.
  always_ff @(posedge clk or posedge weight_flip_reset) begin
    if (weight_flip_reset) begin
      alarm_cnt <= '0;
      alarm     <= 1'b0;
    end else if ((state != OVERLOAD) || leaving) begin
      alarm_cnt <= '0;
      alarm     <= 1'b0;
    end else begin
      if (alarm_cnt != ALARM_C) alarm_cnt <= alarm_cnt + 1'b1;
      alarm <= (alarm_cnt == ALARM_C);
    end
  end
`else
  logic unused_alarm_cfg;
  assign unused_alarm_cfg = ^ALARM_CYCLES;
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_weight_monitor.sv
// Directed bench for weight_monitor: vector table plus timed corner sequences.
`timescale 1ns/1ps
module tb_weight_monitor;

  logic       clk = 1'b0;
  logic       weight_flip_reset;
  logic       door;
  logic       enter_flip;
  logic       exit_flip;
  logic [3:0] occ_a;
  logic       near_a, over_a, hold_a, alarm_a;
  logic [2:0] occ_b;
  logic       near_b, over_b, hold_b, alarm_b;

  always #5 clk = ~clk;

  weight_monitor #(.CW(4), .CAPACITY(5), .WARN_LEVEL(4), .HYST(1), .ALARM_CYCLES(8)) dut_a (
    .clk                   (clk),
    .weight_flip_reset     (weight_flip_reset),
    .door                  (door),
    .enter_flip            (enter_flip),
    .exit_flip             (exit_flip),
    .occupancy             (occ_a),
    .near_limit            (near_a),
    .weight_limit_exceeded (over_a),
    .door_hold             (hold_a),
    .alarm                 (alarm_a)
  );

  weight_monitor #(.CW(3), .CAPACITY(5), .WARN_LEVEL(4), .HYST(1), .ALARM_CYCLES(8)) dut_b (
    .clk                   (clk),
    .weight_flip_reset     (weight_flip_reset),
    .door                  (door),
    .enter_flip            (enter_flip),
    .exit_flip             (exit_flip),
    .occupancy             (occ_b),
    .near_limit            (near_b),
    .weight_limit_exceeded (over_b),
    .door_hold             (hold_b),
    .alarm                 (alarm_b)
  );

`ifdef WEIGHT_ALARM_TIMEOUT_EN
  localparam logic ALARM_ON = 1'b1;
`else
  localparam logic ALARM_ON = 1'b0;
  int alarm_hi = 0;
  always @(negedge clk) if (alarm_a || alarm_b) alarm_hi++;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] kind;   // 0 enter, 1 exit, 2 both
    logic       door;
    logic [3:0] occ;
    logic       near;
    logic       over;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic [1:0] k, input logic d, input logic [3:0] o,
                      input logic n, input logic v);
    vec_t e;
    e.kind = k; e.door = d; e.occ = o; e.near = n; e.over = v;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] kind, input logic d);
    door       = d;
    enter_flip = (kind != 2'd1);
    exit_flip  = (kind != 2'd0);
    tick(4);
    enter_flip = 1'b0;
    exit_flip  = 1'b0;
    tick(6);
  endtask

  task automatic do_reset();
    door = 1'b0; enter_flip = 1'b0; exit_flip = 1'b0;
    weight_flip_reset = 1'b1;
    tick(2);
    weight_flip_reset = 1'b0;
    tick(5);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    addv(0,1,1,0,0); addv(0,1,2,0,0); addv(0,1,3,0,0); addv(0,1,4,1,0);
    addv(0,1,5,1,0); addv(0,1,6,1,1); addv(1,1,5,1,1); addv(1,1,4,1,0);
    addv(0,1,5,1,0); addv(0,0,5,1,0); addv(0,0,5,1,0); addv(0,0,5,1,0);
    addv(2,1,5,1,0); addv(0,1,6,1,1); addv(1,0,6,1,1); addv(1,1,5,1,1);
    addv(1,1,4,1,0); addv(1,1,3,0,0); addv(1,1,2,0,0); addv(1,1,1,0,0);
    addv(1,1,0,0,0); addv(1,1,0,0,0);

    weight_flip_reset = 1'b1; door = 1'b0; enter_flip = 1'b0; exit_flip = 1'b0;
    tick(2);
    @(negedge clk);
    check("reset_occ", occ_a, 0);
    check("reset_near", near_a, 0);
    check("reset_over", over_a, 0);
    check("reset_hold", hold_a, 0);
    check("reset_alarm", alarm_a, 0);
    weight_flip_reset = 1'b0;
    tick(5);

    for (int i = 0; i < vecs.size(); i++) begin
      pulse(vecs[i].kind, vecs[i].door);
      @(negedge clk);
      check($sformatf("vec%0d_occ", i), occ_a, vecs[i].occ);
      check($sformatf("vec%0d_near", i), near_a, vecs[i].near);
      check($sformatf("vec%0d_over", i), over_a, vecs[i].over);
      check($sformatf("vec%0d_hold", i), hold_a, vecs[i].over);
      tick(1);
    end

    // Edge-accurate latency of count and flags, then alarm timing.
    do_reset();
    door = 1'b1;
    repeat (3) pulse(2'd0, 1'b1);
    enter_flip = 1'b1;
    repeat (3) @(negedge clk);
    check("lat_occ_before", occ_a, 3);
    @(negedge clk);
    check("lat_occ_after", occ_a, 4);
    check("lat_near_before", near_a, 0);
    @(negedge clk);
    check("lat_near_after", near_a, 1);
    enter_flip = 1'b0;
    tick(6);
    pulse(2'd0, 1'b1);
    enter_flip = 1'b1;
    repeat (4) @(negedge clk);
    check("ovl_occ", occ_a, 6);
    check("ovl_over_before", over_a, 0);
    @(negedge clk);
    check("ovl_over_after", over_a, 1);
    check("ovl_hold_after", hold_a, 1);
    enter_flip = 1'b0;
    repeat (8) @(negedge clk);
    check("alarm_cycle8", alarm_a, 0);
    @(negedge clk);
    check("alarm_cycle9", alarm_a, ALARM_ON);
    tick(1);
    pulse(2'd1, 1'b1);
    @(negedge clk);
    check("alarm_occ5_occ", occ_a, 5);
    check("alarm_occ5_over", over_a, 1);
    check("alarm_occ5_alarm", alarm_a, ALARM_ON);
    tick(1);
    pulse(2'd1, 1'b1);
    @(negedge clk);
    check("alarm_occ4_over", over_a, 0);
    check("alarm_occ4_alarm", alarm_a, 0);

    // Sensor already high when reset releases must not count.
    weight_flip_reset = 1'b1; door = 1'b1; enter_flip = 1'b1;
    tick(2);
    weight_flip_reset = 1'b0;
    tick(8);
    check("arm_high_occ", occ_a, 0);
    enter_flip = 1'b0;
    tick(6);
    check("arm_low_occ", occ_a, 0);
    pulse(2'd0, 1'b1);
    @(negedge clk);
    check("arm_first_enter", occ_a, 1);

    // Reset mid-operation clears outputs without a clock edge.
    do_reset();
    repeat (3) pulse(2'd0, 1'b1);
    @(negedge clk);
    check("mid_occ3", occ_a, 3);
    #2 weight_flip_reset = 1'b1;
    #1;
    check("mid_rst_occ", occ_a, 0);
    check("mid_rst_near", near_a, 0);
    tick(1);
    weight_flip_reset = 1'b0;
    tick(5);
    pulse(2'd0, 1'b1);
    @(negedge clk);
    check("mid_after_enter", occ_a, 1);

    // Saturation at 2**CW-1 on the narrow instance.
    do_reset();
    repeat (10) pulse(2'd0, 1'b1);
    @(negedge clk);
    check("sat_wide_occ", occ_a, 10);
    check("sat_narrow_occ", occ_b, 7);
    check("sat_narrow_over", over_b, 1);
    check("sat_narrow_hold", hold_b, 1);
    #2 weight_flip_reset = 1'b1;
    #1;
    check("sat_rst_over", over_a, 0);
    check("sat_rst_hold", hold_a, 0);
    check("sat_rst_occ_b", occ_b, 0);
    tick(2);
    weight_flip_reset = 1'b0;
    tick(2);

`ifndef WEIGHT_ALARM_TIMEOUT_EN
    check("alarm_never_high", alarm_hi, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
